// File: rtl/regfile_pkg.sv
// Shared defaults and bus helpers for the bypassing, scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;

  // Widest packed bus the slice helper accepts: 4 ports x 32 bits.
  localparam int SLICE_BUS_W = 128;
  localparam int SLICE_W     = 32;

  // Returns field idx of a packed bus made of width-bit fields. Callers
  // zero-extend the bus and truncate the result to their field width.
  function automatic logic [SLICE_W-1:0] bus_slice(input logic [SLICE_BUS_W-1:0] bus,
                                                   input int idx, input int width);
    return SLICE_W'(bus >> (idx * width));
  endfunction

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard: reserve sets, writeback clears, flush squashes.
module rf_busy_table
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     res_en,
  input  logic [ADDR_W-1:0]        res_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             res_ok;

  assign res_ok = res_en && !(ZERO_REG && res_addr == ADDR_W'(ZERO_ADDR));

  // Later assignments win: flush, then writeback clear, then the newer reserve.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    busy_d = flush ? '0 : busy_q;
    if (wr_en)  busy_d[wr_addr]  = 1'b0;
    if (res_ok) busy_d[res_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state updates use <= so every flop samples pre-edge values.
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero, hit;
    assign addr    = ADDR_W'(bus_slice(SLICE_BUS_W'(rd_addr), p, ADDR_W));
    assign is_zero = ZERO_REG && addr == ADDR_W'(ZERO_ADDR);
    assign hit     = BYPASS && wr_en && wr_addr == addr;
    assign rd_busy[p] = !is_zero && !hit && busy_q[addr];
  end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-port register file with zero register, write-to-read bypass and busy scoreboard.
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     res_en,
  input  logic [ADDR_W-1:0]        res_addr,
  input  logic                     flush
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG && wr_addr == ADDR_W'(ZERO_ADDR));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the array is reset because reads must return 0 right after reset;
      // storage without that need would skip the reset to stay RAM-mappable.
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero, hit;
    assign addr    = ADDR_W'(bus_slice(SLICE_BUS_W'(rd_addr), p, ADDR_W));
    assign is_zero = ZERO_REG && addr == ADDR_W'(ZERO_ADDR);
    assign hit     = BYPASS && wr_en && wr_addr == addr;
    assign rd_data[p*DATA_W +: DATA_W] = is_zero ? '0 :
                                         hit     ? wr_data : regs_q[addr];
  end

  rf_busy_table #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_busy (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .res_en  (res_en),
    .res_addr(res_addr),
    .flush   (flush),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy)
  );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench: a bypassing and a non-bypassing 4-port instance share all inputs.
module tb_regfile_bypass_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data_a, rd_data_b;
  logic [NR-1:0]     rd_busy_a, rd_busy_b;
  logic              wr_en, res_en, flush;
  logic [AW-1:0]     wr_addr, res_addr;
  logic [DW-1:0]     wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_bypass_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .res_en(res_en), .res_addr(res_addr), .flush(flush)
  );

  regfile_bypass_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .res_en(res_en), .res_addr(res_addr), .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] da(input int p);
    return rd_data_a[p*DW +: DW];
  endfunction

  function automatic logic [31:0] db(input int p);
    return rd_data_b[p*DW +: DW];
  endfunction

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    wr_en = 1'b0; res_en = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; res_addr = '0;
    idle();
    #12;
    for (int p = 0; p < NR; p++) begin
      check($sformatf("rst_data_p%0d", p), da(p), 32'h0);
      check($sformatf("rst_busy_p%0d", p), {31'b0, rd_busy_a[p]}, 32'h0);
    end
    reset_n = 1'b1;

    // r5 gets data and a reservation, then an asynchronous mid-cycle reset.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle(); res_en = 1'b1; res_addr = 5'd5;
    tick();
    idle(); set_rd(0, 5'd5); set_rd(1, 5'd5);
    #1;
    check("r5_before_rst", da(0), 32'hDEADBEEF);
    check("r5_busy_before_rst", {31'b0, rd_busy_a[1]}, 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("r5_after_rst", da(0), 32'h0);
    check("r5_busy_after_rst", {28'b0, rd_busy_a}, 32'h0);
    #1 reset_n = 1'b1;

    // Same-cycle bypass on A; B still shows the stored value until the edge.
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; set_rd(0, 5'd7);
    #1;
    check("bypass_a", da(0), 32'h12345678);
    check("nobypass_b", db(0), 32'h0);
    tick();
    idle();
    #1;
    check("nobypass_b_after_edge", db(0), 32'h12345678);

    // Zero register ignores writes and reserves.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    res_en = 1'b1; res_addr = 5'd0; set_rd(0, 5'd0); set_rd(1, 5'd0);
    #1;
    check("r0_data_same_cycle", da(0), 32'h0);
    tick();
    idle();
    #1;
    check("r0_data_p0", da(0), 32'h0);
    check("r0_data_p1", da(1), 32'h0);
    check("r0_busy_p0", {31'b0, rd_busy_a[0]}, 32'h0);
    check("r0_busy_p1", {31'b0, rd_busy_a[1]}, 32'h0);

    // Scoreboard: reserve shows next cycle, writeback clears via bypass.
    res_en = 1'b1; res_addr = 5'd3; set_rd(0, 5'd3);
    #1;
    check("r3_busy_res_cycle", {31'b0, rd_busy_a[0]}, 32'h0);
    tick();
    idle();
    #1;
    check("r3_busy_next", {31'b0, rd_busy_a[0]}, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
    #1;
    check("r3_busy_bypass_a", {31'b0, rd_busy_a[0]}, 32'h0);
    check("r3_data_bypass_a", da(0), 32'hA5);
    check("r3_busy_nobypass_b", {31'b0, rd_busy_b[0]}, 32'h1);
    tick();
    idle();
    #1;
    check("r3_busy_after", {31'b0, rd_busy_a[0]}, 32'h0);
    check("r3_data_after", da(0), 32'hA5);

    // Write and reserve the same register: new data, busy stays set.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; res_en = 1'b1; res_addr = 5'd9;
    tick();
    idle(); set_rd(0, 5'd9);
    #1;
    check("r9_data", da(0), 32'h99);
    check("r9_busy", {31'b0, rd_busy_a[0]}, 32'h1);

    // Flush with a concurrent reserve and write.
    res_en = 1'b1; res_addr = 5'd4;
    tick();
    res_addr = 5'd6;
    tick();
    flush = 1'b1; res_en = 1'b1; res_addr = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hC0FFEE;
    tick();
    idle(); set_rd(0, 5'd4); set_rd(1, 5'd6); set_rd(2, 5'd9); set_rd(3, 5'd12);
    #1;
    check("flush_r4_busy", {31'b0, rd_busy_a[0]}, 32'h0);
    check("flush_r6_busy", {31'b0, rd_busy_a[1]}, 32'h1);
    check("flush_r9_busy", {31'b0, rd_busy_a[2]}, 32'h0);
    check("flush_r12_data", da(3), 32'hC0FFEE);

    // All four ports read independently.
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h55;
    tick();
    wr_addr = 5'd11; wr_data = 32'h66;
    tick();
    idle(); set_rd(0, 5'd10); set_rd(1, 5'd10); set_rd(2, 5'd11); set_rd(3, 5'd10);
    #1;
    check("mp_p0", da(0), 32'h55);
    check("mp_p1", da(1), 32'h55);
    check("mp_p2", da(2), 32'h66);
    check("mp_p3", da(3), 32'h55);
    check("mp_b_p2", db(2), 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
# regfile_bypass_sb

Parametrised successor to the CPU register file. It adds NUM_RD combinational read ports, a hard-wired zero register, and same-cycle write-to-read bypass. It also keeps a per-register busy scoreboard so the pipeline can stall on pending writebacks. It sits between decode (read, reserve) and writeback (write) in the pipelined MIPS core.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reserves
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  1 = port i register has an outstanding reservation
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback address
- wr_data  input  DATA_W  writeback data
- res_en  input  1  reserve strobe from decode: destination will be written later
- res_addr  input  ADDR_W  reserved destination
- flush  input  1  synchronous clear of all busy bits (pipeline squash)

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus a 2**ADDR_W busy-bit vector.
- Write: on a rising edge with wr_en=1, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0. Otherwise regs hold.
- Reserve: on a rising edge with res_en=1, busy[res_addr] <= 1.
- Write and reserve to the same address in one cycle: data is written and busy ends at 1. The reserve belongs to a newer producer, so it wins.
- Flush: all busy bits are cleared to 0. When flush and res_en are both asserted, busy[res_addr] ends at 1. When flush and wr_en are both asserted, the write still occurs.
- ZERO_REG=1:
  - any read of address 0 returns 0 and rd_busy=0
  - writes and reserves to address 0 are discarded
- Read, port i:
  - BYPASS=1 with wr_en=1 and wr_addr==rd_addr[i] (and not the zero address): rd_data=wr_data and rd_busy=0
  - otherwise: rd_data=regs[rd_addr[i]] and rd_busy=busy[rd_addr[i]]
  - res_en does not affect rd_busy until the following cycle
- All read ports are independent. Any number of ports may read the same address.
- Reset (reset_n=0, asynchronous): all registers cleared to 0 and all busy bits cleared to 0. Reset asserted mid-operation discards any pending write or reserve in that cycle.

## Timing
- Read path is combinational from rd_addr, wr_en, wr_addr and wr_data to rd_data and rd_busy. Latency is 0 cycles.
- Write, reserve and flush take effect at the rising edge. They are visible to a non-bypassed read in the next cycle.
- Reset values: rd_data = 0 for every port; rd_busy = 0 for every port.
- Release of reset_n is synchronous to the design clock domain (guaranteed upstream). The first edge after release performs normal operation.
- No handshakes and no backpressure. The caller stalls decode while any used rd_busy is 1.

## Structure
- Package regfile_pkg holds:
  - default DATA_W and ADDR_W
  - the ZERO_ADDR constant
  - a function for per-port slice extraction from the packed address and data buses
- Sub-module rf_busy_table holds:
  - the busy vector
  - the reserve/write/flush priority logic
  - a read of NUM_RD busy bits with bypass clear
- The top level holds the storage array, the data bypass and the zero-register muxing.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert reset_n=0 mid-cycle → r5 reads 0 and every rd_busy=0 immediately, with no clock edge.
- Bypass: wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr[0]=7 in the same cycle → rd_data[0]=0x12345678 combinationally. Repeat with BYPASS=0 → old value 0 until the edge.
- Zero register: write 0xFFFFFFFF to r0 and reserve r0 → r0 reads 0 and rd_busy=0 on both ports.
- Scoreboard: reserve r3 → next cycle rd_busy=1 for r3. Write r3=0xA5 → rd_busy=0 in that same cycle via bypass, and stays 0 after the edge.
- Collisions:
  - write r9 and reserve r9 in one cycle → next cycle r9 data is the new value and busy=1
  - reserve r4 and r6, then flush with res_en on r6 → r4 busy=0, r6 busy=1
- Multi-port: NUM_RD=4, all ports read r10=0x55 while port 2 reads r11=0x66 → each port returns its own value.
